// File: rtl/maj_net_eval.sv
// maj_net_eval: programmable 3-input majority network, one node per clock, single vector or full truth-table sweep
module maj_net_eval #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 8,
    parameter int SEL_W   = $clog2(N_IN + N_NODES + 1),
    parameter int AW      = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [3*(SEL_W+1)-1:0] cfg_data,
    input  logic                   cfg_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sweep,
    input  logic [N_IN-1:0]        in_x,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out,
    output logic [N_IN-1:0]        out_idx,
    output logic                   out_last
);
    localparam int OW = SEL_W + 1;
    localparam int CW = 3 * OW;
    localparam int PW = 2 ** SEL_W;
    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_table [N_NODES];
    logic [AW-1:0]     r_last_idx, r_ptr;
    logic [N_IN-1:0]   r_x;
    logic [N_NODES-1:0] r_nodes;
    logic              r_sweep, r_out;
    logic [PW-1:0]     w_pool;
    logic [CW-1:0]     w_ent;
    logic [2:0]        w_op;
    logic              w_val, w_start, w_done, w_acc, w_more, w_wr;
    // operand pool: bit 0 is constant 0, then inputs, then nodes; out-of-range selects read the zero padding
    assign w_pool = PW'({r_nodes, r_x, 1'b0});
    assign w_ent  = r_table[r_ptr];
    for (genvar i = 0; i < 3; i++) begin : g_op
        assign w_op[i] = w_pool[w_ent[i*OW +: SEL_W]] ^ w_ent[i*OW + SEL_W];
    end
    assign w_val     = (w_op[0] & w_op[1]) | (w_op[0] & w_op[2]) | (w_op[1] & w_op[2]);
    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == HOLD;
    assign w_start   = in_valid && in_ready;
    assign w_done    = r_state == EVAL && r_ptr == r_last_idx;
    assign w_acc     = out_valid && out_ready;
    assign w_more    = r_sweep && !(&r_x);
    assign w_wr      = cfg_we && in_ready && (int'(cfg_addr) < N_NODES);
    assign out       = r_out;
    assign out_idx   = r_x;
    assign out_last  = out_valid && (!r_sweep || &r_x);
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = EVAL;
        else if (w_done) w_next = HOLD;
        else if (w_acc) w_next = w_more ? EVAL : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NODES; k++) r_table[k] <= '0;
            r_last_idx <= '0;
            r_ptr      <= '0;
            r_x        <= '0;
            r_nodes    <= '0;
            r_sweep    <= 1'b0;
            r_out      <= 1'b0;
        end else begin
            if (w_wr) begin
                r_table[cfg_addr] <= cfg_data;
                if (cfg_last) r_last_idx <= cfg_addr;
            end
            if (w_start) begin
                r_x     <= in_sweep ? '0 : in_x;
                r_sweep <= in_sweep;
                r_ptr   <= '0;
                r_nodes <= '0;
            end else if (r_state == EVAL) begin
                r_nodes[r_ptr] <= w_val;
                if (w_done) r_out <= w_val;
                else r_ptr <= r_ptr + AW'(1);
            end else if (w_acc && w_more) begin
                r_x     <= r_x + N_IN'(1);
                r_ptr   <= '0;
                r_nodes <= '0;
            end
        end
    end
endmodule

// File: tb/tb_maj_net_eval.sv
// tb_maj_net_eval: directed vectors, scoreboard queue filled by stimulus and drained by a negedge monitor
module tb_maj_net_eval;
    logic        clk = 0, rst_n = 0;
    logic        cfg_we = 0, cfg_last = 0;
    logic [2:0]  cfg_addr = 0;
    logic [14:0] cfg_data = 0;
    logic        in_valid = 0, in_sweep = 0, in_ready;
    logic [6:0]  in_x = 0, out_idx;
    logic        out_valid, out_ready = 1, out, out_last;
    int          total = 0, bad = 0;
    typedef struct {logic o; logic [6:0] idx; logic last;} exp_t;
    exp_t q[$];

    maj_net_eval dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .in_valid(in_valid), .in_ready(in_ready), .in_sweep(in_sweep),
        .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic mj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic net(input logic [6:0] x);
        logic n0, n1, n2, n3;
        n0 = mj(x[0], x[2], x[3]);
        n1 = mj(x[0], x[3], x[4]);
        n2 = mj(x[4], x[5], x[6]);
        n3 = mj(x[2], n0, n2);
        return mj(x[1], n1, n3);
    endfunction

    function automatic logic [4:0] op(input logic inv, input int sel);
        return {inv, 4'(sel)};
    endfunction

    function automatic logic [14:0] ent(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected beat: idx %0d out %0b", out_idx, out);
            end else begin
                chk($sformatf("out[%0d]", q[0].idx), out, q[0].o);
                chk("out_idx", out_idx, q[0].idx);
                chk($sformatf("out_last[%0d]", q[0].idx), out_last, q[0].last);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic cfg(input int addr, input logic [14:0] data, input logic last);
        cfg_we = 1; cfg_addr = 3'(addr); cfg_data = data; cfg_last = last;
        @(posedge clk); #1;
        cfg_we = 0; cfg_last = 0;
    endtask

    task automatic program_net();
        cfg(0, ent(op(0, 1), op(0, 3), op(0, 4)), 0);
        cfg(1, ent(op(0, 1), op(0, 4), op(0, 5)), 0);
        cfg(2, ent(op(0, 5), op(0, 6), op(0, 7)), 0);
        cfg(3, ent(op(0, 3), op(0, 8), op(0, 10)), 0);
        cfg(4, ent(op(0, 2), op(0, 9), op(0, 11)), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("return to idle", in_ready, 1);
    endtask

    task automatic run_single(input logic [6:0] x, input logic e, input int lat, input bit midcfg);
        int n = 0;
        in_valid = 1; in_sweep = 0; in_x = x;
        q.push_back('{e, x, 1'b1});
        @(posedge clk); #1;
        in_valid = 0;
        if (midcfg) begin
            cfg_we = 1; cfg_addr = 4; cfg_data = '0; cfg_last = 1;
        end
        do begin
            @(posedge clk); #1; n++;
            cfg_we = 0; cfg_last = 0;
        end while (!out_valid && n < 50);
        chk($sformatf("latency x=%0h", x), n, lat);
        wait_idle();
    endtask

    task automatic run_sweep(input int bp_idx, input int rst_idx);
        int n = 0;
        bit bp_done = 0;
        in_valid = 1; in_sweep = 1; in_x = 7'h55;
        for (int i = 0; i < 128; i++) q.push_back('{net(7'(i)), 7'(i), i == 127});
        @(posedge clk); #1;
        in_valid = 0; in_sweep = 0;
        chk("in_ready low in sweep", in_ready, 0);
        while (q.size() > 0 && n < 3000) begin
            if (out_valid && int'(out_idx) == bp_idx && !bp_done) begin
                out_ready = 0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1;
                bp_done = 1;
            end
            if (out_valid && int'(out_idx) == rst_idx) begin
                rst_n = 0;
                #1;
                chk("rst out_valid", out_valid, 0);
                chk("rst in_ready", in_ready, 1);
                chk("rst out_idx", out_idx, 0);
                q.delete();
                #2 rst_n = 1;
            end
            @(posedge clk); #1; n++;
        end
        chk("sweep beats left", q.size(), 0);
        q.delete();
        wait_idle();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out", out, 0);
        chk("reset out_idx", out_idx, 0);
        chk("reset out_last", out_last, 0);
        rst_n = 1;
        @(posedge clk); #1;
        program_net();
        run_single(7'h7F, 1, 5, 0);
        run_single(7'h00, 0, 5, 0);
        run_single(7'h17, 1, 5, 0);
        run_sweep(5, -1);
        run_single(7'h17, 1, 5, 1);
        run_single(7'h17, 1, 5, 0);
        run_single(7'h2C, net(7'h2C), 5, 0);
        // n3 holds 1 from the previous vector; a forward reference must still read 0
        cfg(0, ent(op(0, 11), op(0, 1), op(0, 2)), 1);
        run_single(7'h01, 0, 1, 0);
        cfg(0, ent(op(1, 0), op(0, 1), op(0, 2)), 1);
        run_single(7'h01, 1, 1, 0);
        run_single(7'h00, 0, 1, 0);
        run_single(7'h02, 1, 1, 0);
        program_net();
        run_sweep(-1, 40);
        run_single(7'h7F, 0, 1, 0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
